// File: rtl/dirty_scan.sv
// Flush/writeback scanner: walks every set of the L1 dirty-bit regfile, issues one writeback
// request per dirty way and clears that bit through the shared regfile write port.
module dirty_scan #(
   parameter int unsigned SETS = 8192,
   parameter int unsigned AW   = 13,
   parameter int unsigned CW   = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush_req,
   output logic          flush_busy,
   output logic          flush_done,
   output logic [CW-1:0] flush_wb_cnt,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [AW-1:0] wb_set,
   output logic [1:0]    wb_way,
   output logic          bit_req,
   input  logic          bit_gnt,
   output logic [AW-1:0] bit_ra,
   output logic [AW-1:0] bit_wa,
   output logic [3:0]    bit_way_sel,
   output logic          bit_wr,
   output logic          bit_d,
   input  logic [3:0]    bit_q
);

   typedef enum logic [2:0] {StIdle, StRead, StIssue, StClear, StDone} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] set_q, set_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] wb_cnt_q, wb_cnt_d;
   logic [3:0]    vec_q, vec_d;

   logic [1:0]    way;
   logic [3:0]    way_oh;
   logic [3:0]    vec_clr;
   logic          last_set;

   // Ways are served lowest index first.
   always_comb begin
      way = 2'd0;
      if (vec_q[0]) begin
         way = 2'd0;
      end else if (vec_q[1]) begin
         way = 2'd1;
      end else if (vec_q[2]) begin
         way = 2'd2;
      end else if (vec_q[3]) begin
         way = 2'd3;
      end
   end

   assign way_oh   = 4'b0001 << way;
   assign vec_clr  = vec_q & ~way_oh;
   assign last_set = (set_q == AW'(SETS - 1));

   assign bit_d        = 1'b0;
   assign flush_busy   = (state_q != StIdle);
   assign flush_wb_cnt = (state_q == StDone) ? cnt_q : wb_cnt_q;

   always_comb begin
      state_d     = state_q;
      set_d       = set_q;
      cnt_d       = cnt_q;
      vec_d       = vec_q;
      wb_cnt_d    = wb_cnt_q;
      flush_done  = 1'b0;
      wb_valid    = 1'b0;
      wb_set      = '0;
      wb_way      = 2'd0;
      bit_req     = 1'b0;
      bit_ra      = '0;
      bit_wa      = '0;
      bit_way_sel = 4'b0000;
      bit_wr      = 1'b0;

      // Regfile addresses track the current set so read-modify-write stays on one set.
      if (state_q != StIdle) begin
         bit_ra = set_q;
         bit_wa = set_q;
      end

      unique case (state_q)
         StIdle: begin
            if (flush_req) begin
               set_d   = '0;
               cnt_d   = '0;
               vec_d   = 4'b0000;
               state_d = StRead;
            end
         end
         StRead: begin
            bit_req = 1'b1;
            if (bit_gnt) begin
               vec_d = bit_q;
               if (bit_q != 4'b0000) begin
                  state_d = StIssue;
               end else if (last_set) begin
                  state_d = StDone;
               end else begin
                  set_d = set_q + AW'(1);
               end
            end
         end
         StIssue: begin
            wb_valid = 1'b1;
            wb_set   = set_q;
            wb_way   = way;
            if (wb_ready) begin
               cnt_d   = cnt_q + CW'(1);
               state_d = StClear;
            end
         end
         StClear: begin
            bit_req     = 1'b1;
            bit_way_sel = way_oh;
            bit_wr      = bit_gnt;
            if (bit_gnt) begin
               vec_d = vec_clr;
               if (vec_clr != 4'b0000) begin
                  state_d = StIssue;
               end else if (last_set) begin
                  state_d = StDone;
               end else begin
                  set_d   = set_q + AW'(1);
                  state_d = StRead;
               end
            end
         end
         StDone: begin
            flush_done = 1'b1;
            wb_cnt_d   = cnt_q;
            state_d    = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         set_q    <= '0;
         cnt_q    <= '0;
         wb_cnt_q <= '0;
         vec_q    <= 4'b0000;
      end else begin
         state_q  <= state_d;
         set_q    <= set_d;
         cnt_q    <= cnt_d;
         wb_cnt_q <= wb_cnt_d;
         vec_q    <= vec_d;
      end
   end

endmodule
